// File: rtl/aqalu_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
package aqalu_pkg;

  localparam int unsigned OPND_W = 2;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] OP_AND  = 4'h0;
  localparam logic [OP_W-1:0] OP_OR   = 4'h1;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h2;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h3;
  localparam logic [OP_W-1:0] OP_SHR  = 4'h4;
  localparam logic [OP_W-1:0] OP_MUL  = 4'h5;
  localparam logic [OP_W-1:0] OP_NOT  = 4'h6;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h7;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h8;
  localparam logic [OP_W-1:0] OP_RSUM = 4'hF;

  typedef struct packed {
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/aqalu_rr_pick.sv
// Winner selection between two requesters; round-robin by default,
// fixed priority to requester 0 when AQALU_ARB_FIXED_PRIO_EN is defined.
module aqalu_rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic last,
  output logic win_c
);

  always_comb begin
    win_c = 1'b0;
`ifdef AQALU_ARB_FIXED_PRIO_EN
    if (!v0 && v1) win_c = 1'b1;
`else
    // On a tie the requester not granted last time wins
    if (v0 && v1)  win_c = ~last;
    else if (v1)   win_c = 1'b1;
`endif
  end

endmodule

// File: rtl/aqalu_arbiter.sv
// Two-requester arbiter for a shared external ALU: accept, hold operands, return result.
// Optional fixed-priority build via AQALU_ARB_FIXED_PRIO_EN.
module aqalu_arbiter
  import aqalu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_result,
  output logic              busy,
  output logic              grant_id
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  alu_req_t         req_q;
  logic             win_c;
  logic             take_c;
  logic             rsp_hs_c;

  aqalu_rr_pick u_pick (
    .v0    (req0_valid),
    .v1    (req1_valid),
    .last  (last),
    .win_c (win_c)
  );

  // Readies only in IDLE, and only to the winner
  assign take_c     = !rst && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = take_c && !win_c;
  assign req1_ready = take_c && win_c;
  assign rsp_hs_c   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign alu_a  = req_q.a;
  assign alu_b  = req_q.b;
  assign alu_op = req_q.op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      req_q      <= '0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            req_q    <= win_c ? alu_req_t'{a: req1_a, b: req1_b, op: req1_op}
                              : alu_req_t'{a: req0_a, b: req0_b, op: req0_op};
            grant_id <= win_c;
            cnt      <= CNT_W'(HOLD_CYCLES - 1);
            busy     <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_data   <= alu_result;
            rsp0_valid <= !grant_id;
            rsp1_valid <= grant_id;
            state      <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_hs_c) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            last       <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aqalu_arbiter.sv
// Self-checking bench for aqalu_arbiter: directed scenarios plus randomized rounds
// against a transaction-level model; honours AQALU_ARB_FIXED_PRIO_EN.
module tb_aqalu_arbiter;
  import aqalu_pkg::*;

  localparam int unsigned H1 = 1;
  localparam int unsigned H4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (HOLD_CYCLES = 1)
  logic       req0_valid = 0, req1_valid = 0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 0, rsp1_ready = 0;
  logic [7:0] rsp_data, alu_result;
  logic [1:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic       busy, grant_id;

  // Second instance (HOLD_CYCLES = 4), only requester 0 used
  logic       h_req0_valid = 0, h_req1_valid = 0;
  logic       h_req0_ready, h_req1_ready;
  logic [1:0] h_req0_a = 0, h_req0_b = 0, h_req1_a = 0, h_req1_b = 0;
  logic [3:0] h_req0_op = 0, h_req1_op = 0;
  logic       h_rsp0_valid, h_rsp1_valid;
  logic       h_rsp0_ready = 0, h_rsp1_ready = 0;
  logic [7:0] h_rsp_data, h_alu_result;
  logic [1:0] h_alu_a, h_alu_b;
  logic [3:0] h_alu_op;
  logic       h_busy, h_grant_id;

  int total = 0;
  int bad   = 0;
  bit last_g = 1'b1;

  // Behavioural stand-in for the shared ALU
  function automatic logic [7:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_AND:  return 8'(a & b);
      OP_OR:   return 8'(a | b);
      OP_XOR:  return 8'(a ^ b);
      OP_MUL:  return 8'(a) * 8'(b);
      OP_ADD:  return 8'(a) + 8'(b);
      OP_SUB:  return 8'(a) - 8'(b);
      OP_RSUM: return 8'(a) + 8'(b) + 8'h10;
      default: return {op, a, b};
    endcase
  endfunction

  assign alu_result   = alu_fn(alu_a, alu_b, alu_op);
  assign h_alu_result = alu_fn(h_alu_a, h_alu_b, h_alu_op);

  function automatic bit model_pick(input bit v0, input bit v1, input bit last);
`ifdef AQALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    if (v0 && v1) return !last;
    return v1;
`endif
  endfunction

  aqalu_arbiter #(.HOLD_CYCLES(H1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy), .grant_id(grant_id)
  );

  aqalu_arbiter #(.HOLD_CYCLES(H4)) u_dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(h_req0_valid), .req0_ready(h_req0_ready), .req0_a(h_req0_a),
    .req0_b(h_req0_b), .req0_op(h_req0_op),
    .req1_valid(h_req1_valid), .req1_ready(h_req1_ready), .req1_a(h_req1_a),
    .req1_b(h_req1_b), .req1_op(h_req1_op),
    .rsp0_valid(h_rsp0_valid), .rsp0_ready(h_rsp0_ready),
    .rsp1_valid(h_rsp1_valid), .rsp1_ready(h_rsp1_ready),
    .rsp_data(h_rsp_data), .alu_a(h_alu_a), .alu_b(h_alu_b), .alu_op(h_alu_op),
    .alu_result(h_alu_result), .busy(h_busy), .grant_id(h_grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy), 32'(0));
    check({tag, "_gid"},   32'(grant_id), 32'(0));
    check({tag, "_rsp0"},  32'(rsp0_valid), 32'(0));
    check({tag, "_rsp1"},  32'(rsp1_valid), 32'(0));
    check({tag, "_rdy0"},  32'(req0_ready), 32'(0));
    check({tag, "_rdy1"},  32'(req1_ready), 32'(0));
    check({tag, "_data"},  32'(rsp_data), 32'(0));
    check({tag, "_alu"},   32'({alu_a, alu_b, alu_op}), 32'(0));
  endtask

  // One transaction on the main instance; entered in IDLE just after a negedge.
  task automatic round(input bit v0, input bit v1,
                       input logic [1:0] a0, input logic [1:0] b0, input logic [3:0] op0,
                       input logic [1:0] a1, input logic [1:0] b1, input logic [3:0] op1,
                       input int bp, input bit keep);
    bit         win, lose_v;
    logic [1:0] ea, eb;
    logic [3:0] eop;
    logic [7:0] ed;
    win    = model_pick(v0, v1, last_g);
    lose_v = win ? v0 : v1;
    ea  = win ? a1 : a0;
    eb  = win ? b1 : b0;
    eop = win ? op1 : op0;
    ed  = alu_fn(ea, eb, eop);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    #1;
    check("idle_rdy0", 32'(req0_ready), 32'(v0 && !win));
    check("idle_rdy1", 32'(req1_ready), 32'(v1 && win));
    check("idle_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    if (win) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!keep) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    for (int j = 0; j < int'(H1); j++) begin
      @(negedge clk);
      check("exec_rsp",  32'({rsp0_valid, rsp1_valid}), 32'(0));
      check("exec_busy", 32'(busy), 32'(1));
      check("exec_alu",  32'({alu_a, alu_b, alu_op}), 32'({ea, eb, eop}));
      check("exec_rdy",  32'({req0_ready, req1_ready}), 32'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("resp_v0",   32'(rsp0_valid), 32'(!win));
    check("resp_v1",   32'(rsp1_valid), 32'(win));
    check("resp_data", 32'(rsp_data), 32'(ed));
    check("resp_gid",  32'(grant_id), 32'(win));
    check("resp_alu",  32'({alu_a, alu_b, alu_op}), 32'({ea, eb, eop}));
    for (int i = 0; i < bp; i++) begin
      // Ready on the non-granted channel must not complete the response
      if (win) rsp0_ready = 1'($urandom); else rsp1_ready = 1'($urandom);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", 32'({rsp0_valid, rsp1_valid}), 32'(win ? 2'b01 : 2'b10));
      check("bp_data",  32'(rsp_data), 32'(ed));
      check("bp_rdy",   32'({req0_ready, req1_ready}), 32'(0));
    end
    rsp0_ready = !win; rsp1_ready = win;
    @(posedge clk); #1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    last_g = win;
    @(negedge clk);
    check("done_busy", 32'(busy), 32'(0));
    check("done_rsp",  32'({rsp0_valid, rsp1_valid}), 32'(0));
    check("done_rdy_loser", 32'(win ? req0_ready : req1_ready), 32'(keep && lose_v));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    #1;

    // Single request, add 2+3
    round(1, 0, 2'd2, 2'd3, OP_ADD, 2'd0, 2'd0, OP_AND, 0, 0);
    check("single_data", 32'(rsp_data), 32'(8'h05));

    // Reset in the middle of EXEC abandons the operation
    req0_valid = 1'b1; req0_a = 2'd3; req0_b = 2'd2; req0_op = OP_XOR;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    req0_valid = 1'b0;
    last_g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_norsp", 32'({rsp0_valid, rsp1_valid, busy}), 32'(0));
    end

    // Simultaneous rounds, requesters held valid; second round backpressured
    round(1, 1, 2'd3, 2'd3, OP_MUL, 2'd3, 2'd1, OP_AND, 0, 1);
    round(1, 1, 2'd3, 2'd3, OP_MUL, 2'd3, 2'd1, OP_AND, 5, 1);
    round(1, 1, 2'd1, 2'd2, OP_RSUM, 2'd2, 2'd2, OP_ADD, 1, 1);
    round(1, 1, 2'd2, 2'd1, OP_SUB, 2'd1, 2'd3, OP_RSUM, 2, 0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("rand_idle", 32'({req0_ready, req1_ready, busy, rsp0_valid, rsp1_valid}), 32'(0));
        continue;
      end
      round(v0, v1, 2'($urandom), 2'($urandom), 4'($urandom),
            2'($urandom), 2'($urandom), 4'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // HOLD_CYCLES=4 instance: sub 1-2
    @(negedge clk);
    h_req0_valid = 1'b1; h_req0_a = 2'd1; h_req0_b = 2'd2; h_req0_op = OP_SUB;
    #1;
    check("h4_rdy", 32'(h_req0_ready), 32'(1));
    @(posedge clk); #1;
    h_req0_valid = 1'b0;
    for (int j = 0; j < int'(H4); j++) begin
      @(negedge clk);
      check("h4_exec_rsp", 32'({h_rsp0_valid, h_rsp1_valid}), 32'(0));
      check("h4_exec_alu", 32'({h_alu_a, h_alu_b, h_alu_op}), 32'({2'd1, 2'd2, OP_SUB}));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("h4_rsp_v",    32'({h_rsp0_valid, h_rsp1_valid}), 32'(2'b10));
    check("h4_rsp_data", 32'(h_rsp_data), 32'(8'hFF));
    h_rsp0_ready = 1'b1;
    @(posedge clk); #1;
    h_rsp0_ready = 1'b0;
    @(negedge clk);
    check("h4_done", 32'({h_busy, h_rsp0_valid}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
